// File: rtl/aquila_dev_axil_master.sv
// aquila_dev_axil_master
// Bridges the uncached device-window request port of the Aquila core into
// single-beat AXI4-Lite master transactions, one outstanding at a time.
// Every request is answered with exactly one dev_data_ready_o pulse.
//
// Optional feature: define AQUILA_DEV_TIMEOUT_EN to add a watchdog that
// abandons a transaction after TIMEOUT_CYCLES busy cycles, flags an error
// and still completes the request toward the core (reads return DEAD_BEEF).
// Without the macro the bridge waits indefinitely for the slave.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for dev_strobe_i; request fields latched on strobe
// RD_A  | arvalid high, waiting for arready
// RD_D  | rready high, waiting for rvalid
// WR    | awvalid/wvalid high until each channel has handshaken
// WR_B  | bready high, waiting for bvalid
// DONE  | transaction finished; ready pulse issued on the way to IDLE

module aquila_dev_axil_master #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                dev_strobe_i,
    input  logic [XLEN-1:0]     dev_addr_i,
    input  logic                dev_rw_i,
    input  logic [XLEN/8-1:0]   dev_byte_enable_i,
    input  logic [XLEN-1:0]     dev_data_i,
    output logic                dev_data_ready_o,
    output logic [XLEN-1:0]     dev_data_o,
    output logic                dev_err_o,
    input  logic                dev_err_clr_i,

    output logic [XLEN-1:0]     m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [XLEN-1:0]     m_axi_wdata,
    output logic [XLEN/8-1:0]   m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [XLEN-1:0]     m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [XLEN-1:0]     m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_D = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_WR_B = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]        state_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN/8-1:0] be_q;
    logic [XLEN-1:0]   rdata_q;

    logic arvalid_q;
    logic rready_q;
    logic awvalid_q;
    logic wvalid_q;
    logic bready_q;
    logic ready_q;
    logic err_q;

    logic aw_done;
    logic w_done;
    logic err_event;
    logic timeout_hit;

    // A write channel counts as finished once its valid has dropped or is
    // handshaking this cycle; the two channels are tracked independently.
    assign aw_done = !awvalid_q || m_axi_awready;
    assign w_done  = !wvalid_q  || m_axi_wready;

`ifdef AQUILA_DEV_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wdog_q;
    logic        busy;

    assign busy = (state_q == S_RD_A) || (state_q == S_RD_D) ||
                  (state_q == S_WR)   || (state_q == S_WR_B);

    // Busy-cycle counter; cleared whenever no transaction is in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q <= '0;
        end else if (busy) begin
            wdog_q <= wdog_q + 16'd1;
        end else begin
            wdog_q <= '0;
        end
    end

    assign timeout_hit = busy && (wdog_q == WDOG_LAST);
`else
    logic [15:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
    assign timeout_hit = 1'b0;
`endif

    // Only the upper response bit distinguishes SLVERR/DECERR from OKAY/EXOKAY.
    logic unused_resp_lsb;
    assign unused_resp_lsb = ^{m_axi_rresp[0], m_axi_bresp[0]};

    assign err_event = ((state_q == S_RD_D) && m_axi_rvalid && m_axi_rresp[1]) ||
                       ((state_q == S_WR_B) && m_axi_bvalid && m_axi_bresp[1]) ||
                       timeout_hit;

    // Request sequencing: latch on strobe, walk the AXI channels, pulse ready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (dev_strobe_i) begin
                        addr_q  <= dev_addr_i;
                        wdata_q <= dev_data_i;
                        be_q    <= dev_byte_enable_i;
                        if (dev_rw_i) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_A;
                        end
                    end
                end

                S_RD_A: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_D;
                    end
                end

                S_RD_D: begin
                    if (m_axi_rvalid) begin
                        rdata_q  <= m_axi_rdata;
                        rready_q <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end

                S_WR: begin
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (m_axi_wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_B;
                    end
                end

                S_WR_B: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end

                S_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Watchdog expiry overrides whatever the channel logic decided.
            if (timeout_hit) begin
                arvalid_q <= 1'b0;
                rready_q  <= 1'b0;
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                bready_q  <= 1'b0;
                state_q   <= S_DONE;
                if ((state_q == S_RD_A) || (state_q == S_RD_D)) begin
                    rdata_q <= XLEN'(32'hDEAD_BEEF);
                end
            end
        end
    end

    // Sticky error flag; an explicit clear wins over a same-cycle error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (dev_err_clr_i) begin
            err_q <= 1'b0;
        end else if (err_event) begin
            err_q <= 1'b1;
        end
    end

    assign dev_data_ready_o = ready_q;
    assign dev_data_o       = rdata_q;
    assign dev_err_o        = err_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = be_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_aquila_dev_axil_master.sv
// Bench for aquila_dev_axil_master: directed vector table, hand-written
// reset/clear sequences, and randomized transactions against a reference
// model derived from the request/response rules (latency, data, error).
module tb_aquila_dev_axil_master;

`ifdef AQUILA_DEV_TIMEOUT_EN
    localparam int TB_TO = 16;
`else
    localparam int TB_TO = 1024;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        dev_strobe_i = 1'b0;
    logic [31:0] dev_addr_i = '0;
    logic        dev_rw_i = 1'b0;
    logic [3:0]  dev_byte_enable_i = '0;
    logic [31:0] dev_data_i = '0;
    logic        dev_data_ready_o;
    logic [31:0] dev_data_o;
    logic        dev_err_o;
    logic        dev_err_clr_i = 1'b0;

    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    aquila_dev_axil_master #(.XLEN(32), .TIMEOUT_CYCLES(TB_TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .dev_strobe_i(dev_strobe_i), .dev_addr_i(dev_addr_i), .dev_rw_i(dev_rw_i),
        .dev_byte_enable_i(dev_byte_enable_i), .dev_data_i(dev_data_i),
        .dev_data_ready_o(dev_data_ready_o), .dev_data_o(dev_data_o),
        .dev_err_o(dev_err_o), .dev_err_clr_i(dev_err_clr_i),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // slave configuration for the current transaction
    int          ar_d = 0, r_d = 0, aw_d = 0, w_d = 0, b_d = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0, s_bresp = '0;

    // observations collected by the slave process
    int          ar_hs = 0, aw_hs = 0, w_hs = 0, ready_cnt = 0, proto_err = 0;
    logic [31:0] ar_addr_seen = '0, aw_addr_seen = '0, w_data_seen = '0;
    logic [3:0]  w_strb_seen = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Responding AXI4-Lite slave with per-channel wait counts, plus protocol
    // observation (valid must not drop or change payload before handshake).
    initial begin : slave
        int ar_w, r_w, aw_w, w_w, b_w;
        logic p_ar, p_arr, p_aw, p_awr, p_w, p_wr;
        logic [31:0] p_araddr, p_awaddr, p_wdata;
        logic [3:0] p_wstrb;
        ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
        p_ar = 0; p_arr = 0; p_aw = 0; p_awr = 0; p_w = 0; p_wr = 0;
        p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = '0;
        forever begin
            @(negedge clk_i);
            if (dev_data_ready_o) ready_cnt++;
            if (rst_ni) begin
                if (p_ar && !p_arr && (!m_axi_arvalid || m_axi_araddr != p_araddr)) proto_err++;
                if (p_aw && !p_awr && (!m_axi_awvalid || m_axi_awaddr != p_awaddr)) proto_err++;
                if (p_w && !p_wr && (!m_axi_wvalid || m_axi_wdata != p_wdata || m_axi_wstrb != p_wstrb)) proto_err++;
            end
            if (m_axi_arvalid) begin
                if (ar_w >= ar_d) begin
                    m_axi_arready = 1; ar_hs++; ar_addr_seen = m_axi_araddr;
                end else begin
                    m_axi_arready = 0; ar_w++;
                end
            end else begin
                m_axi_arready = 0; ar_w = 0;
            end
            if (m_axi_rready) begin
                if (r_w >= r_d) begin
                    m_axi_rvalid = 1; m_axi_rdata = s_rdata; m_axi_rresp = s_rresp;
                end else begin
                    m_axi_rvalid = 0; r_w++;
                end
            end else begin
                m_axi_rvalid = 0; r_w = 0;
            end
            if (m_axi_awvalid) begin
                if (aw_w >= aw_d) begin
                    m_axi_awready = 1; aw_hs++; aw_addr_seen = m_axi_awaddr;
                end else begin
                    m_axi_awready = 0; aw_w++;
                end
            end else begin
                m_axi_awready = 0; aw_w = 0;
            end
            if (m_axi_wvalid) begin
                if (w_w >= w_d) begin
                    m_axi_wready = 1; w_hs++; w_data_seen = m_axi_wdata; w_strb_seen = m_axi_wstrb;
                end else begin
                    m_axi_wready = 0; w_w++;
                end
            end else begin
                m_axi_wready = 0; w_w = 0;
            end
            if (m_axi_bready) begin
                if (b_w >= b_d) begin
                    m_axi_bvalid = 1; m_axi_bresp = s_bresp;
                end else begin
                    m_axi_bvalid = 0; b_w++;
                end
            end else begin
                m_axi_bvalid = 0; b_w = 0;
            end
            p_ar = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr;
            p_aw = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr;
            p_w = m_axi_wvalid; p_wr = m_axi_wready; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
        end
    end

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        int          ar_d, r_d, aw_d, w_d, b_d;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          extra_at;
        logic        clr_hold;
        int          exp_lat;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input logic rw, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] data, input int ard, input int rd,
                                input int awd, input int wd, input int bd,
                                input logic [31:0] rdata, input logic [1:0] resp,
                                input int extra_at, input logic clr_hold, input int exp_lat,
                                input logic [31:0] exp_data, input logic exp_err);
        vec_t v;
        v.rw = rw; v.addr = addr; v.be = be; v.data = data;
        v.ar_d = ard; v.r_d = rd; v.aw_d = awd; v.w_d = wd; v.b_d = bd;
        v.rdata = rdata; v.resp = resp; v.extra_at = extra_at; v.clr_hold = clr_hold;
        v.exp_lat = exp_lat; v.exp_data = exp_data; v.exp_err = exp_err;
        return v;
    endfunction

    // Issue one request, optionally inject an ignored strobe while busy,
    // then check latency, single ready pulse, channel traffic and results.
    task automatic run_txn(input vec_t v, input string tag);
        int  lat;
        bit  seen;
        @(negedge clk_i);
        ar_d = v.ar_d; r_d = v.r_d; aw_d = v.aw_d; w_d = v.w_d; b_d = v.b_d;
        s_rdata = v.rdata; s_rresp = v.resp; s_bresp = v.resp;
        ar_hs = 0; aw_hs = 0; w_hs = 0; ready_cnt = 0;
        dev_err_clr_i = v.clr_hold;
        dev_strobe_i = 1; dev_rw_i = v.rw; dev_addr_i = v.addr;
        dev_byte_enable_i = v.be; dev_data_i = v.data;
        lat = 0; seen = 0;
        while (!seen && lat < 300) begin
            @(negedge clk_i);
            lat++;
            dev_strobe_i = (lat == v.extra_at);
            if (lat == v.extra_at) begin
                dev_rw_i = ~v.rw; dev_addr_i = v.addr ^ 32'h0000_0F00;
                dev_data_i = ~v.data; dev_byte_enable_i = ~v.be;
            end
            if (dev_data_ready_o) seen = 1;
        end
        dev_strobe_i = 0;
        check({tag, " ready_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, " rdata_out"}, dev_data_o, v.exp_data);
        dev_err_clr_i = 0;
        @(negedge clk_i);
        #1;
        check({tag, " ready_pulses"}, 32'(ready_cnt), 32'd1);
        check({tag, " err"}, 32'(dev_err_o), 32'(v.exp_err));
        check({tag, " no_new_txn"}, {29'd0, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}, 32'd0);
        check({tag, " proto"}, 32'(proto_err), 32'd0);
        if (v.rw) begin
            check({tag, " aw_hs"}, 32'(aw_hs), 32'd1);
            check({tag, " w_hs"}, 32'(w_hs), 32'd1);
            check({tag, " ar_hs"}, 32'(ar_hs), 32'd0);
            check({tag, " awaddr"}, aw_addr_seen, v.addr);
            check({tag, " wdata"}, w_data_seen, v.data);
            check({tag, " wstrb"}, 32'(w_strb_seen), 32'(v.be));
        end else begin
            check({tag, " ar_hs"}, 32'(ar_hs), 32'd1);
            check({tag, " aw_hs"}, 32'(aw_hs), 32'd0);
            check({tag, " araddr"}, ar_addr_seen, v.addr);
        end
    endtask

    initial begin : global_guard
        #600000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin : main
        vec_t        vecs[9];
        vec_t        v;
        logic [31:0] model_data;
        logic        model_err;
        int          n;

        vecs[0] = mk(0, 32'hC000_0010, 4'hF, 32'h0, 0,0,0,0,0, 32'h1234_5678, 2'b00, 0, 0, 4, 32'h1234_5678, 0);
        vecs[1] = mk(1, 32'hC000_0004, 4'b0011, 32'hA5A5_A5A5, 0,0,3,0,0, 32'h0, 2'b00, 0, 0, 7, 32'h1234_5678, 0);
        vecs[2] = mk(0, 32'hC000_0100, 4'hF, 32'h0, 5,7,0,0,0, 32'hCAFE_F00D, 2'b00, 3, 0, 16, 32'hCAFE_F00D, 0);
        vecs[3] = mk(1, 32'hC000_0008, 4'hF, 32'h0000_0001, 0,0,0,2,1, 32'h0, 2'b10, 0, 0, 7, 32'hCAFE_F00D, 1);
        vecs[4] = mk(0, 32'hC000_000C, 4'hF, 32'h0, 0,0,0,0,0, 32'h1111_1111, 2'b00, 3, 0, 4, 32'h1111_1111, 1);
        vecs[5] = mk(1, 32'hC000_0020, 4'b1100, 32'h55AA_55AA, 0,0,2,2,0, 32'h0, 2'b01, 2, 0, 6, 32'h1111_1111, 1);
        vecs[6] = mk(0, 32'hC000_0030, 4'hF, 32'h0, 0,0,0,0,0, 32'hDEAD_C0DE, 2'b11, 0, 0, 4, 32'hDEAD_C0DE, 1);
        vecs[7] = mk(0, 32'hC000_0034, 4'hF, 32'h0, 0,0,0,0,0, 32'h0BAD_F00D, 2'b10, 0, 1, 4, 32'h0BAD_F00D, 0);
        vecs[8] = mk(1, 32'hC000_0040, 4'b0001, 32'h0000_0012, 0,0,1,4,2, 32'h0, 2'b11, 0, 0, 10, 32'h0BAD_F00D, 1);

        // power-on reset
        #2 rst_ni = 0;
        #2;
        check("rst ready", 32'(dev_data_ready_o), 32'd0);
        check("rst data", dev_data_o, 32'd0);
        check("rst err", 32'(dev_err_o), 32'd0);
        check("rst valids", {27'd0, m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'd0);
        check("prot tie", {26'd0, m_axi_awprot, m_axi_arprot}, 32'd0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1;
        repeat (2) @(negedge clk_i);

        foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

        // sticky error persists across idle cycles, then a one-cycle clear
        repeat (3) @(negedge clk_i);
        check("err sticky", 32'(dev_err_o), 32'd1);
        dev_err_clr_i = 1;
        @(negedge clk_i);
        dev_err_clr_i = 0;
        #1 check("err cleared", 32'(dev_err_o), 32'd0);

        // set the error again, then reset in the middle of a read data phase
        run_txn(mk(0, 32'hC000_0050, 4'hF, 32'h0, 0,0,0,0,0, 32'h7777_7777, 2'b10, 0, 0, 4, 32'h7777_7777, 1), "pre_rst");
        @(negedge clk_i);
        ar_d = 0; r_d = 10;
        dev_strobe_i = 1; dev_rw_i = 0; dev_addr_i = 32'hC000_0060;
        @(negedge clk_i);
        dev_strobe_i = 0;
        n = 0;
        while (!m_axi_rready && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("rst_mid reached_rd_d", 32'(m_axi_rready), 32'd1);
        #2 rst_ni = 0;
        #1;
        check("rst_mid valids", {27'd0, m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'd0);
        check("rst_mid data", dev_data_o, 32'd0);
        check("rst_mid err", 32'(dev_err_o), 32'd0);
        check("rst_mid ready", 32'(dev_data_ready_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1;
        run_txn(mk(0, 32'hC000_0070, 4'hF, 32'h0, 1,1,0,0,0, 32'h8888_0001, 2'b00, 0, 0, 6, 32'h8888_0001, 0), "post_rst");

        // randomized traffic against the reference model
        model_data = 32'h8888_0001;
        model_err = 0;
        for (int k = 0; k < 40; k++) begin
            v.rw = 1'($urandom_range(0, 1));
            v.addr = 32'hC000_0000 | ($urandom & 32'h0FFF_FFFC);
            v.be = 4'($urandom);
            v.data = $urandom;
            v.ar_d = $urandom_range(0, 3); v.r_d = $urandom_range(0, 3);
            v.aw_d = $urandom_range(0, 3); v.w_d = $urandom_range(0, 3); v.b_d = $urandom_range(0, 3);
            v.rdata = $urandom;
            v.resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            v.clr_hold = ($urandom_range(0, 7) == 0);
            if (v.rw) v.exp_lat = 4 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.b_d;
            else      v.exp_lat = 4 + v.ar_d + v.r_d;
            v.extra_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, v.exp_lat - 1) : 0;
            v.exp_data = v.rw ? model_data : v.rdata;
            v.exp_err = v.clr_hold ? 1'b0 : (model_err | v.resp[1]);
            model_data = v.exp_data;
            model_err = v.exp_err;
            run_txn(v, $sformatf("rnd%0d", k));
        end

`ifdef AQUILA_DEV_TIMEOUT_EN
        // slave never accepts the address: watchdog must complete the read
        @(negedge clk_i);
        ar_d = 1000000; ready_cnt = 0;
        dev_strobe_i = 1; dev_rw_i = 0; dev_addr_i = 32'hC000_0080;
        n = 0;
        @(negedge clk_i);
        dev_strobe_i = 0;
        n = 1;
        while (!dev_data_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("timeout ready_seen", 32'(dev_data_ready_o), 32'd1);
        check("timeout lat_window", 32'((n >= TB_TO) && (n <= TB_TO + 4)), 32'd1);
        check("timeout data", dev_data_o, 32'hDEAD_BEEF);
        check("timeout arvalid", 32'(m_axi_arvalid), 32'd0);
        @(negedge clk_i);
        #1 check("timeout err", 32'(dev_err_o), 32'd1);
        ar_d = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
